spi_target_shifter: RTL and testbench
=====================================

# spi_target_shifter

SPI target-side (responder) byte shifter: the opposite end of the controller's SPI master shifter. Oversamples an external SCLK/MOSI/CS_N, returns bytes on MISO, and runs the same CRC16 so SD-style data blocks can be checked or generated. Used as the card-side model in system benches and as the core of a target-mode bridge. Supports SPI mode 0, MSB first.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock. One clock domain; every flop uses its rising edge.
- rst  in  1  reset. Synchronous, active-high.
- cs_n  in  1  SPI chip select from master, active-low, asynchronous.
- sclk  in  1  SPI clock from master, asynchronous, idles low.
- mosi  in  1  SPI data from master, asynchronous.
- miso  out  1  SPI data to master.
- miso_oe  out  1  MISO output enable for the pad. Equals synchronized ~cs_n.
- tx_data  in  8  next byte to return.
- tx_load  in  1  one-cycle strobe that writes tx_data into the holding register.
- tx_ready  out  1  holding register is empty.
- rx_data  out  8  last complete received byte.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- underrun  out  1  one-cycle pulse when a byte is started with the holding register empty.
- crc_reset  in  1  clears crc_out.
- crc_source  in  1  CRC input select. 0 = MOSI bits, 1 = MISO bits.
- crc_out  out  16  CRC16 state.
- busy  out  1  byte in progress: bit counter is non-zero.

## Operation
- **Synchronization**
  - cs_n, sclk and mosi each pass through a 2-flop synchronizer.
  - sclk rise and fall are detected from the synchronized value plus one delay flop.
- **Selection**
  - A synchronized cs_n falling edge loads the tx shift register.
  - The load takes the holding register if it is full and marks it empty.
  - If the holding register is empty, the load takes 8'hFF and pulses underrun.
- **Rising SCLK while selected**
  - Shift the synchronized MOSI into the rx shift register.
  - Increment the 3-bit bit counter.
  - Update the CRC.
  - On the 8th rise (counter wraps 7→0): rx_data <= the completed byte and rx_valid pulses.
- **Falling SCLK while selected**
  - Counter == 0: load the tx shift register with the same rule as selection (holding register or 8'hFF plus underrun).
  - Otherwise: shift the tx register left by one bit.
- **Outputs**
  - miso = tx_shift[7] while selected, 1 while deselected.
- **CRC**
  - Polynomial x^16+x^12+x^5+1, initial value 0, no final XOR.
  - in = (crc_source ? current MISO bit : sampled MOSI bit) ^ crc[15].
  - Next state = {crc[14:12], in^crc[11], crc[10:5], in^crc[4], crc[3:0], in}.
  - If a shift and crc_reset occur in the same cycle, the shift wins.
- **Holding register**
  - tx_load while tx_ready: store tx_data, tx_ready <= 0.
  - tx_load while full: ignored, with no change.
  - tx_load in the same cycle as a load event with the holding register empty: the load uses 8'hFF and pulses underrun; tx_data is stored for the next byte. There is no bypass path.
- **cs_n deassert mid-byte**
  - Bit counter and rx shift register clear.
  - No rx_valid is issued.
  - The in-flight tx byte is lost; the holding register is retained.
- **SCLK edges while deselected**: ignored.

## Timing
- Reset values:
  - miso=1, miso_oe=0, tx_ready=1
  - rx_data=8'h00, rx_valid=0, underrun=0
  - crc_out=16'h0000, busy=0
  - bit counter and shift registers 0
- Internal latency:
  - Pad edge to internal edge detect: 3 clk.
  - rx_valid asserts 3 clk after the 8th SCLK rise on the pad.
  - MISO changes 3 clk after the SCLK fall on the pad.
- Supported master rate: each SCLK phase lasts at least 4 clk, i.e. the master runs at clk/8 or slower in target-clock terms.
- cs_n setup: cs_n must go low at least 4 clk before the first SCLK rise, so MISO bit 7 is valid.
- Refill deadline: to avoid underrun, tx_load must occur before the falling edge that follows the 8th rise.

## Structure
- Shared package spi_pkg holds:
  - CRC16 tap constants
  - IDLE_FILL = 8'hFF
  - SPI speed codes DIV34/DIV6/TURBO, shared with the master side
- Sub-module sync_edge (2-flop synchronizer, delay flop, rise/fall outputs), instantiated for sclk and cs_n. mosi uses only the 2-flop path.
- Target size: 150–250 lines of RTL.

## Test plan
- **Single byte exchange**: tx_load 8'hA5, then a clk/8 mode-0 master sends 8'h3C.
  - MISO bits are 1,0,1,0,0,1,0,1.
  - rx_data=8'h3C with one rx_valid pulse.
  - tx_ready returns to 1.
- **Underrun**: no tx_load; master sends two bytes.
  - MISO reads 8'hFF, 8'hFF.
  - Two underrun pulses: one at CS fall, one at the byte-1→2 boundary.
- **Back-to-back bytes**: tx_load 8'h12 before CS; tx_load 8'h34 during byte 1.
  - Master reads 8'h12, 8'h34.
  - No underrun.
- **CRC of an SD data block**: crc_reset, crc_source=0, master sends 512 × 8'hFF → crc_out=16'h7FA1.
  - Repeat with crc_source=1 and 512 preloaded 8'hFF → same value.
- **Chip-select abort**: cs_n rises after 5 bits.
  - No rx_valid; busy=0.
  - A new CS with byte 8'h81 gives rx_data=8'h81.
- **Reset mid-byte**: rst for 1 clk after 3 bits.
  - All outputs return to their reset values on the next edge.
  - The next full byte is received correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI constants: CRC16 taps, idle fill byte, master speed codes.
// Latency: n/a (package). Backpressure: n/a.
// Used by both the controller-side and target-side shifters.
package spi_pkg;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [7:0]  IDLE_FILL  = 8'hFF;

    typedef enum logic [1:0] {
        DIV34 = 2'd0,
        DIV6  = 2'd1,
        TURBO = 2'd2
    } spi_speed_t;

    // One serial step of CRC16-CCITT (x^16+x^12+x^5+1), MSB-first.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = bit_in ^ crc[15];
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/spi_target_shifter_sync_edge.sv
// 2-flop synchronizer plus delay flop giving single-cycle rise/fall strobes.
// Latency: pad change to rise/fall strobe is 2 clk (acted on at the 3rd edge).
// Backpressure: none; every input edge produces exactly one strobe.
module sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic dly;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1  <= RST_VAL;
            s2  <= RST_VAL;
            dly <= RST_VAL;
        end else begin
            s1  <= din;
            s2  <= s1;
            dly <= s2;
        end
    end

    assign dout = s2;
    assign rise = s2 & ~dly;
    assign fall = ~s2 & dly;

endmodule

// File: rtl/spi_target_shifter.sv
// SPI mode-0 target byte shifter with single-entry tx holding register and CRC16.
// Latency: pad SCLK edge to shift/rx_valid/MISO change is 3 clk.
// Backpressure: none; an empty holding register at a byte start sends IDLE_FILL and pulses underrun.
module spi_target_shifter
    import spi_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cs_n,
    input  logic        sclk,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    input  logic [7:0]  tx_data,
    input  logic        tx_load,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        underrun,
    input  logic        crc_reset,
    input  logic        crc_source,
    output logic [15:0] crc_out,
    output logic        busy
);

    logic       cs_s, cs_rise, cs_fall;
    logic       sclk_s, sclk_rise, sclk_fall;
    logic       mosi_s1, mosi_s;
    logic       sel;
    logic       load_evt;
    logic       shift_evt;
    logic [2:0] bit_cnt;
    logic [7:0] rx_shift;
    logic [7:0] tx_shift;
    logic [7:0] hold;
    logic       crc_bit;

    sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (cs_n),
        .dout (cs_s),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sclk),
        .dout (sclk_s),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mosi_s1 <= 1'b0;
            mosi_s  <= 1'b0;
        end else begin
            mosi_s1 <= mosi;
            mosi_s  <= mosi_s1;
        end
    end

    // A deselect arriving with the final SCLK fall sees sel low, so no extra byte load.
    assign sel       = ~cs_s;
    assign shift_evt = sel & sclk_rise;
    assign load_evt  = cs_fall | (sel & sclk_fall & (bit_cnt == 3'd0));
    assign crc_bit   = crc_source ? tx_shift[7] : mosi_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt  <= 3'd0;
            rx_shift <= 8'h00;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (cs_rise) begin
                bit_cnt  <= 3'd0;
                rx_shift <= 8'h00;
            end else if (shift_evt) begin
                rx_shift <= {rx_shift[6:0], mosi_s};
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    rx_data  <= {rx_shift[6:0], mosi_s};
                    rx_valid <= 1'b1;
                end
            end
        end
    end

    // tx_ready doubles as the holding-register empty flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_shift <= 8'h00;
            hold     <= 8'h00;
            tx_ready <= 1'b1;
            underrun <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (load_evt) begin
                if (!tx_ready) begin
                    tx_shift <= hold;
                    tx_ready <= 1'b1;
                end else begin
                    tx_shift <= IDLE_FILL;
                    underrun <= 1'b1;
                end
            end else if (sel && sclk_fall) begin
                tx_shift <= {tx_shift[6:0], 1'b0};
            end
            if (tx_load && tx_ready) begin
                hold     <= tx_data;
                tx_ready <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_out <= 16'h0000;
        end else if (shift_evt) begin
            crc_out <= crc16_step(crc_out, crc_bit);
        end else if (crc_reset) begin
            crc_out <= 16'h0000;
        end
    end

    assign miso    = sel ? tx_shift[7] : 1'b1;
    assign miso_oe = sel;
    assign busy    = (bit_cnt != 3'd0);

endmodule

// File: tb/tb_spi_target_shifter.sv
// Directed bench for spi_target_shifter acting as a clk/8 mode-0 SPI master.
module tb_spi_target_shifter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs_n;
    logic        sclk;
    logic        mosi;
    logic        miso;
    logic        miso_oe;
    logic [7:0]  tx_data;
    logic        tx_load;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        underrun;
    logic        crc_reset;
    logic        crc_source;
    logic [15:0] crc_out;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int rxv_cnt = 0;
    int und_cnt = 0;
    logic [7:0] last_rx = 8'h00;

    spi_target_shifter dut (
        .clk        (clk),
        .rst        (rst),
        .cs_n       (cs_n),
        .sclk       (sclk),
        .mosi       (mosi),
        .miso       (miso),
        .miso_oe    (miso_oe),
        .tx_data    (tx_data),
        .tx_load    (tx_load),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .underrun   (underrun),
        .crc_reset  (crc_reset),
        .crc_source (crc_source),
        .crc_out    (crc_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) begin
            rxv_cnt = rxv_cnt + 1;
            last_rx = rx_data;
        end
        if (underrun) und_cnt = und_cnt + 1;
    end

    task automatic cs_start();
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_load(input logic [7:0] v);
        tx_data = v;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    // Shifts nbits MSB-first; when last is set, cs_n rises together with the final SCLK fall.
    task automatic spi_xfer(input logic [7:0] mo, input int nbits, input bit last,
                            input bit do_load, input logic [7:0] load_val,
                            output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = mo[i];
            if (do_load && i == 5) begin
                tx_data = load_val;
                tx_load = 1'b1;
            end
            @(negedge clk);
            tx_load = 1'b0;
            repeat (3) @(negedge clk);
            mi[i] = miso;
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            if (last && i == 8 - nbits) cs_n = 1'b1;
            sclk = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (miso !== 1'b1) begin errors++; $display("FAIL reset_miso got %b want 1", miso); end
        checks++; if (miso_oe !== 1'b0) begin errors++; $display("FAIL reset_miso_oe got %b want 0", miso_oe); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready got %b want 1", tx_ready); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
        checks++; if (crc_out !== 16'h0000) begin errors++; $display("FAIL reset_crc got %h want 0000", crc_out); end
        checks++; if (busy !== 1'b0 || rx_valid !== 1'b0 || underrun !== 1'b0) begin
            errors++; $display("FAIL reset_flags got busy=%b rxv=%b und=%b want 0", busy, rx_valid, underrun);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_single_byte();
        logic [7:0] mi;
        int rx0, un0;
        rx0 = rxv_cnt; un0 = und_cnt;
        pulse_load(8'hA5);
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL single_tx_ready_full got %b want 0", tx_ready); end
        cs_start();
        checks++; if (miso_oe !== 1'b1) begin errors++; $display("FAIL single_miso_oe got %b want 1", miso_oe); end
        spi_xfer(8'h3C, 8, 1'b1, 1'b0, 8'h00, mi);
        repeat (8) @(negedge clk);
        checks++; if (mi !== 8'hA5) begin errors++; $display("FAIL single_miso got %h want a5", mi); end
        checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL single_rx_data got %h want 3c", rx_data); end
        checks++; if (rxv_cnt - rx0 !== 1) begin errors++; $display("FAIL single_rx_valid got %0d pulses want 1", rxv_cnt - rx0); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL single_tx_ready got %b want 1", tx_ready); end
        checks++; if (und_cnt - un0 !== 0) begin errors++; $display("FAIL single_underrun got %0d pulses want 0", und_cnt - un0); end
    endtask

    task automatic test_underrun();
        logic [7:0] mi0, mi1;
        int un0;
        un0 = und_cnt;
        cs_start();
        spi_xfer(8'h00, 8, 1'b0, 1'b0, 8'h00, mi0);
        spi_xfer(8'h00, 8, 1'b1, 1'b0, 8'h00, mi1);
        repeat (8) @(negedge clk);
        checks++; if (mi0 !== 8'hFF) begin errors++; $display("FAIL underrun_byte0 got %h want ff", mi0); end
        checks++; if (mi1 !== 8'hFF) begin errors++; $display("FAIL underrun_byte1 got %h want ff", mi1); end
        checks++; if (und_cnt - un0 !== 2) begin errors++; $display("FAIL underrun_pulses got %0d want 2", und_cnt - un0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] mi0, mi1;
        int un0, rx0;
        un0 = und_cnt; rx0 = rxv_cnt;
        pulse_load(8'h12);
        cs_start();
        spi_xfer(8'h5A, 8, 1'b0, 1'b1, 8'h34, mi0);
        spi_xfer(8'hC6, 8, 1'b1, 1'b0, 8'h00, mi1);
        repeat (8) @(negedge clk);
        checks++; if (mi0 !== 8'h12) begin errors++; $display("FAIL b2b_byte0 got %h want 12", mi0); end
        checks++; if (mi1 !== 8'h34) begin errors++; $display("FAIL b2b_byte1 got %h want 34", mi1); end
        checks++; if (und_cnt - un0 !== 0) begin errors++; $display("FAIL b2b_underrun got %0d want 0", und_cnt - un0); end
        checks++; if (rxv_cnt - rx0 !== 2 || last_rx !== 8'hC6) begin
            errors++; $display("FAIL b2b_rx got %0d pulses last %h want 2 pulses last c6", rxv_cnt - rx0, last_rx);
        end
    endtask

    task automatic test_crc_block();
        logic [7:0] mi;
        int un0;
        crc_source = 1'b0;
        crc_reset = 1'b1;
        @(negedge clk);
        crc_reset = 1'b0;
        checks++; if (crc_out !== 16'h0000) begin errors++; $display("FAIL crc_clear got %h want 0000", crc_out); end
        cs_start();
        for (int k = 0; k < 512; k++) spi_xfer(8'hFF, 8, k == 511, 1'b0, 8'h00, mi);
        repeat (8) @(negedge clk);
        checks++; if (crc_out !== 16'h7FA1) begin errors++; $display("FAIL crc_mosi got %h want 7fa1", crc_out); end

        crc_source = 1'b1;
        crc_reset = 1'b1;
        @(negedge clk);
        crc_reset = 1'b0;
        un0 = und_cnt;
        pulse_load(8'hFF);
        cs_start();
        for (int k = 0; k < 512; k++) spi_xfer(8'h00, 8, k == 511, 1'b1, 8'hFF, mi);
        repeat (8) @(negedge clk);
        checks++; if (crc_out !== 16'h7FA1) begin errors++; $display("FAIL crc_miso got %h want 7fa1", crc_out); end
        checks++; if (und_cnt - un0 !== 0) begin errors++; $display("FAIL crc_miso_underrun got %0d want 0", und_cnt - un0); end
        crc_source = 1'b0;
    endtask

    task automatic test_cs_abort();
        logic [7:0] mi;
        int rx0;
        rx0 = rxv_cnt;
        cs_start();
        spi_xfer(8'hF0, 5, 1'b0, 1'b0, 8'h00, mi);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_mid got %b want 1", busy); end
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        checks++; if (rxv_cnt - rx0 !== 0) begin errors++; $display("FAIL abort_rx_valid got %0d want 0", rxv_cnt - rx0); end
        cs_start();
        spi_xfer(8'h81, 8, 1'b1, 1'b0, 8'h00, mi);
        repeat (8) @(negedge clk);
        checks++; if (rx_data !== 8'h81 || rxv_cnt - rx0 !== 1) begin
            errors++; $display("FAIL abort_next got %h/%0d want 81/1", rx_data, rxv_cnt - rx0);
        end
    endtask

    task automatic test_reset_mid_byte();
        logic [7:0] mi;
        int rx0;
        cs_start();
        spi_xfer(8'hE0, 3, 1'b0, 1'b1, 8'h5A, mi);
        checks++; if (tx_ready !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre got ready=%b busy=%b want 0/1", tx_ready, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cs_n = 1'b1;
        checks++; if (miso !== 1'b1 || miso_oe !== 1'b0) begin
            errors++; $display("FAIL rstmid_pins got miso=%b oe=%b want 1/0", miso, miso_oe);
        end
        checks++; if (tx_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_state got ready=%b busy=%b want 1/0", tx_ready, busy);
        end
        checks++; if (rx_data !== 8'h00 || crc_out !== 16'h0000) begin
            errors++; $display("FAIL rstmid_data got rx=%h crc=%h want 00/0000", rx_data, crc_out);
        end
        checks++; if (rx_valid !== 1'b0 || underrun !== 1'b0) begin
            errors++; $display("FAIL rstmid_pulses got rxv=%b und=%b want 0/0", rx_valid, underrun);
        end
        repeat (8) @(negedge clk);
        rx0 = rxv_cnt;
        cs_start();
        spi_xfer(8'hC3, 8, 1'b1, 1'b0, 8'h00, mi);
        repeat (8) @(negedge clk);
        checks++; if (rx_data !== 8'hC3 || rxv_cnt - rx0 !== 1) begin
            errors++; $display("FAIL rstmid_next got %h/%0d want c3/1", rx_data, rxv_cnt - rx0);
        end
    endtask

    initial begin
        rst = 1'b1;
        cs_n = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        tx_data = 8'h00;
        tx_load = 1'b0;
        crc_reset = 1'b0;
        crc_source = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_byte();
        test_underrun();
        test_back_to_back();
        test_crc_block();
        test_cs_abort();
        test_reset_mid_byte();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
